// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-side and D-side miss handlers, one word transaction at a time.
// Latency: grant at the edge after req; strobes held until mem_ready or watchdog; ready pulse one cycle later.
// Backpressure: a requester holds req until its ready pulse; the losing side waits in IDLE, with no queueing.
//
// Ports:
//   clk, reset (async, active low)
//   i_req/i_addr -> i_ready/i_rdata/i_err        instruction-side read channel
//   d_req/d_wen/d_addr/d_wdata/d_bsel -> d_ready/d_rdata/d_err   data-side channel
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_bsel -> memory, mem_rdata/mem_ready <- memory
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_bsel,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_bsel,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int WD_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            owner_d;   // 1: current transaction belongs to the D side
   logic            last_d;    // 1: most recently completed transaction was D side
   logic [WD_W-1:0] wd_cnt;

   logic            req_any;
   logic            grant_d;
   logic            timeout;

   assign req_any = i_req | d_req;
   // On a tie the side that was not served last wins; last starts as I, so D wins the first tie.
   assign grant_d = d_req & (~i_req | ~last_d);
   assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = BUSY;
         BUSY:    if (mem_ready || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_d   <= 1'b0;
         last_d    <= 1'b0;
         wd_cnt    <= '0;
         mem_ren   <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_bsel  <= 4'h0;
         i_ready   <= 1'b0;
         i_rdata   <= '0;
         i_err     <= 1'b0;
         d_ready   <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  owner_d <= grant_d;
                  wd_cnt  <= '0;
                  if (grant_d) begin
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_bsel  <= d_bsel;
                     mem_ren   <= ~d_wen;
                     mem_wen   <= d_wen;
                  end else begin
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                     mem_bsel  <= 4'hF;
                     mem_ren   <= 1'b1;
                     mem_wen   <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (wd_cnt != {WD_W{1'b1}}) wd_cnt <= wd_cnt + WD_W'(1);
               // A completion in the final watchdog cycle still counts as success.
               if (mem_ready || timeout) begin
                  mem_ren <= 1'b0;
                  mem_wen <= 1'b0;
                  if (owner_d) begin
                     d_ready <= 1'b1;
                     d_rdata <= mem_ready ? mem_rdata : '0;
                     d_err   <= ~mem_ready;
                  end else begin
                     i_ready <= 1'b1;
                     i_rdata <= mem_ready ? mem_rdata : '0;
                     i_err   <= ~mem_ready;
                  end
               end
            end
            RESP: begin
               last_d  <= owner_d;
               i_ready <= 1'b0;
               i_rdata <= '0;
               i_err   <= 1'b0;
               d_ready <= 1'b0;
               d_rdata <= '0;
               d_err   <= 1'b0;
            end
            default: begin
               mem_ren <= 1'b0;
               mem_wen <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_bsel;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_bsel;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int checks;
   int errors;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_bsel(d_bsel),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_bsel(mem_bsel), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL sim_timeout: simulation did not finish within time limit");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_wen;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_bsel;
      logic        mr;
      logic [31:0] mrd;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_bsel;
      logic        e_irdy;
      logic [31:0] e_irdata;
      logic        e_ierr;
      logic        e_drdy;
      logic [31:0] e_drdata;
      logic        e_derr;
   } vec_t;

   vec_t vecs [10];

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_bsel = 4'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
   endtask

   initial begin
      logic       i_hold;
      logic       d_hold;
      int         n;
      logic [3:0] order;

      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle_inputs();

      // Lone I read (rows 0-4), then a D write whose inputs change mid-transaction (rows 5-9).
      vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5555,
                  1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[2] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h5555,
                  1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[3] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                  1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[4] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1111,
                  1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'h3, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h0, 4'h3, 1'b0, 32'h0,
                  1'b0, 1'b1, 32'h20, 32'h12345678, 4'h3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h99, 32'h0, 4'hC, 1'b1, 32'h0,
                  1'b0, 1'b1, 32'h20, 32'h12345678, 4'h3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h99, 32'h0, 4'hC, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h20, 32'h12345678, 4'h3, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
      vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 32'h20, 32'h12345678, 4'h3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};

      #22 reset = 1'b1;

      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         i_req = vecs[k].i_req;   i_addr = vecs[k].i_addr;
         d_req = vecs[k].d_req;   d_wen = vecs[k].d_wen;   d_addr = vecs[k].d_addr;
         d_wdata = vecs[k].d_wdata; d_bsel = vecs[k].d_bsel;
         mem_ready = vecs[k].mr;  mem_rdata = vecs[k].mrd;
         @(negedge clk);
         chk($sformatf("v%0d_mem_ren", k),   32'(mem_ren),   32'(vecs[k].e_ren));
         chk($sformatf("v%0d_mem_wen", k),   32'(mem_wen),   32'(vecs[k].e_wen));
         chk($sformatf("v%0d_mem_addr", k),  mem_addr,       vecs[k].e_addr);
         chk($sformatf("v%0d_mem_wdata", k), mem_wdata,      vecs[k].e_wdata);
         chk($sformatf("v%0d_mem_bsel", k),  32'(mem_bsel),  32'(vecs[k].e_bsel));
         chk($sformatf("v%0d_i_ready", k),   32'(i_ready),   32'(vecs[k].e_irdy));
         chk($sformatf("v%0d_i_rdata", k),   i_rdata,        vecs[k].e_irdata);
         chk($sformatf("v%0d_i_err", k),     32'(i_err),     32'(vecs[k].e_ierr));
         chk($sformatf("v%0d_d_ready", k),   32'(d_ready),   32'(vecs[k].e_drdy));
         chk($sformatf("v%0d_d_rdata", k),   d_rdata,        vecs[k].e_drdata);
         chk($sformatf("v%0d_d_err", k),     32'(d_err),     32'(vecs[k].e_derr));
      end

      // Both sides requesting from reset: expect D, I, D, I with a one-cycle memory.
      @(negedge clk); reset = 1'b0; idle_inputs();
      @(negedge clk); #2 reset = 1'b1;
      i_hold = 1'b0; d_hold = 1'b0; n = 0; order = 4'h0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         i_req = ~i_hold; i_addr = 32'h100;
         d_req = ~d_hold; d_addr = 32'h200; d_wen = 1'b0;
         mem_ready = mem_ren | mem_wen;
         mem_rdata = mem_addr ^ 32'hA5A5_0000;
         @(negedge clk);
         chk("arb_single_ready", 32'(i_ready & d_ready), 32'h0);
         if (d_ready) begin
            chk("arb_d_rdata", d_rdata, 32'hA5A5_0200);
            if (n < 4) order[n] = 1'b1;
            n++;
         end
         if (i_ready) begin
            chk("arb_i_rdata", i_rdata, 32'hA5A5_0100);
            if (n < 4) order[n] = 1'b0;
            n++;
         end
         i_hold = i_ready;
         d_hold = d_ready;
      end
      chk("arb_pulse_count", 32'(n), 32'd4);
      chk("arb_order", 32'(order), 32'h5);

      // D read the memory never answers: watchdog fires 8 cycles after BUSY entry.
      @(posedge clk); #1;
      idle_inputs();
      d_req = 1'b1; d_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (c == 1) chk("to_ren_c1", 32'(mem_ren), 32'h1);
         if (c == 8) begin
            chk("to_ren_c8", 32'(mem_ren), 32'h1);
            chk("to_dready_c8", 32'(d_ready), 32'h0);
         end
         if (c == 9) begin
            chk("to_ren_c9", 32'(mem_ren), 32'h0);
            chk("to_dready_c9", 32'(d_ready), 32'h1);
            chk("to_derr_c9", 32'(d_err), 32'h1);
            chk("to_drdata_c9", d_rdata, 32'h0);
            chk("to_iready_c9", 32'(i_ready), 32'h0);
         end
      end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      chk("to_dready_after", 32'(d_ready), 32'h0);
      chk("to_derr_after", 32'(d_err), 32'h0);
      // Tie after a D transaction goes to I.
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h500; d_wen = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("tie2_addr", mem_addr, 32'h400);
      chk("tie2_ren", 32'(mem_ren), 32'h1);
      chk("tie2_wen", 32'(mem_wen), 32'h0);
      chk("tie2_bsel", 32'(mem_bsel), 32'hF);
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("tie2_iready", 32'(i_ready), 32'h1);
      chk("tie2_irdata", i_rdata, 32'hCAFEF00D);
      chk("tie2_ierr", 32'(i_err), 32'h0);
      chk("tie2_dready", 32'(d_ready), 32'h0);
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      chk("tie2_iready_off", 32'(i_ready), 32'h0);

      // mem_ready while IDLE is ignored.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = 32'h7777;
         @(negedge clk);
         chk("idle_mr_ready", 32'(i_ready | d_ready), 32'h0);
         chk("idle_mr_ren", 32'(mem_ren | mem_wen), 32'h0);
      end

      // New I read; reset asserted mid-BUSY drops strobes at once.
      @(posedge clk); #1 mem_ready = 1'b0; i_req = 1'b1; i_addr = 32'h600;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_ren", 32'(mem_ren), 32'h1);
      chk("rst_pre_addr", mem_addr, 32'h600);
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1;
      chk("rst_async_ren", 32'(mem_ren), 32'h0);
      chk("rst_async_addr", mem_addr, 32'h0);
      @(negedge clk); i_req = 1'b0;
      @(negedge clk); #2 reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_no_ready", 32'(i_ready | d_ready), 32'h0);
         chk("rst_no_ren", 32'(mem_ren), 32'h0);
      end

      // After release the arbiter is IDLE and serves a fresh D read.
      @(posedge clk); #1 d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h700; d_bsel = 4'h5;
      @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE;
      @(negedge clk);
      chk("post_rst_ren", 32'(mem_ren), 32'h1);
      chk("post_rst_addr", mem_addr, 32'h700);
      chk("post_rst_bsel", 32'(mem_bsel), 32'h5);
      @(posedge clk); #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_dready", 32'(d_ready), 32'h1);
      chk("post_rst_drdata", d_rdata, 32'h0BAD_CAFE);
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      chk("post_rst_dready_off", 32'(d_ready), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backing memory port between the instruction-side and data-side cache miss handlers. Each requester presents one word transaction at a time. The arbiter selects one requester, drives the memory for the whole transaction, and returns data with a one-cycle ready pulse. It sits between the two cache controllers and the shared memory model. A watchdog aborts transactions the memory never completes.

## Interface
- ADDR_W, 32, word address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 64, max BUSY cycles before abort (>=2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-side read request (level, held until i_ready)
- i_addr  in  ADDR_W  instruction-side word address
- i_ready  out  1  one-cycle completion pulse
- i_rdata  out  DATA_W  read data, valid while i_ready=1
- i_err  out  1  timeout flag, valid with i_ready
- d_req  in  1  data-side request (level, held until d_ready)
- d_wen  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data-side word address
- d_wdata  in  DATA_W  write data
- d_bsel  in  4  byte-enable vector
- d_ready  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  read data, valid while d_ready=1
- d_err  out  1  timeout flag, valid with d_ready
- mem_ren  out  1  memory read strobe, held for transaction
- mem_wen  out  1  memory write strobe, held for transaction
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_bsel  out  4  latched byte enables; 4'b1111 for I-side
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, sampled high for one cycle

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if exactly one req is high, grant it. If both are high, grant the side not granted last; the `last` flag resets to I, so D wins the first tie. At the grant edge, latch owner, addr, wdata, bsel and wen, clear the watchdog, and go to BUSY.
- BUSY: mem_ren = ~wen_latched and mem_wen = wen_latched, both held constant. Requester inputs are ignored (latched copies drive memory).
  - On mem_ready=1: capture mem_rdata (writes capture too; data is don't-care), err=0, go to RESP.
  - On watchdog reaching TIMEOUT_CYC-1 without mem_ready: err=1, rdata=0, drop strobes, go to RESP.
- RESP: owner's ready=1 for exactly one cycle, with rdata/err. Update last=owner. Return to IDLE.
- The requester must deassert req on the edge ending its ready cycle. A req still high in IDLE is treated as a new transaction.
- The non-owner's ready, rdata and err are 0 at all times.
- Watchdog: counter of $clog2(TIMEOUT_CYC) bits, increments each BUSY cycle, saturates, cleared on grant.
- mem_ready outside BUSY is ignored.
- Reset (asserted low): immediately sets state=IDLE, last=I, all outputs 0, and mem_ren/mem_wen drop asynchronously. An in-flight transaction is abandoned with no ready pulse.

## Timing
- Strobes and mem_addr are registered outputs. rdata, ready and err are registered.
- Request high in cycle 0 -> grant edge -> BUSY from cycle 1 -> memory asserts mem_ready in cycle k (k>=1) -> RESP in cycle k+1 (ready pulse) -> IDLE in cycle k+2.
- Minimum round trip (mem_ready in cycle 1): ready in cycle 2; next grant at the end of cycle 3.
- Back-to-back same requester: one IDLE cycle between transactions.
- Timeout: ready+err appear TIMEOUT_CYC cycles after BUSY entry.

## Test plan
- Reset low mid-BUSY (mem_ren=1) -> mem_ren=0 in the same cycle. No ready pulse; IDLE after release.
- Lone I read of addr 0x10, mem_ready at cycle 3 with mem_rdata=0xDEADBEEF -> mem_bsel=4'hF and mem_ren=1 for cycles 1-3. i_ready=1 with i_rdata=0xDEADBEEF in cycle 4 only; d_ready stays 0.
- D write addr 0x20, wdata 0x12345678, bsel 4'b0011; d_wdata changed to 0 during BUSY -> mem_wen=1, mem_wdata=0x12345678, mem_bsel=4'b0011 held. d_ready pulse with d_err=0.
- Both req asserted from reset, held, each re-raised after ready -> grant order D, I, D, I. Exactly one ready pulse per transaction.
- D read with mem_ready never asserted, TIMEOUT_CYC=8 -> strobes drop and d_ready=1, d_err=1, d_rdata=0 eight cycles after BUSY entry. Next transaction runs normally.
- mem_ready pulsed while IDLE -> no state change and no ready output.
